// File: rtl/fetch_pc_ifid.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory and fills the IF/ID register.
// Handles stall, redirect-with-flush and an END state once the PC leaves program memory.
//
//  state | meaning
//  RUN   | fetching sequentially from program memory
//  END   | PC ran past program memory; inserting bubbles until a redirect
module fetch_pc_ifid #(
    parameter int MEM_WORDS = 32,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inStall,
    input  logic             inBranchTaken,
    input  logic [31:0]      inBranchTarget,
    output logic [31:0]      outPC,
    input  logic [31:0]      inInstruction,
    output logic [31:0]      outInstrIFID,
    output logic [31:0]      outPCplus1IFID,
    output logic             outValidIFID,
    output logic             outEnd,
    output logic [CNT_W-1:0] outFetchCount
);

    typedef enum logic {
        S_RUN = 1'b0,
        S_END = 1'b1
    } state_t;

    localparam logic [31:0] MEM_LIMIT = 32'(MEM_WORDS);

    state_t            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic [31:0]       pcp1_q, pcp1_d;
    logic              valid_q, valid_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       pc_inc;

    assign pc_inc = pc_q + 32'd1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_RUN;
            pc_q    <= 32'h0;
            instr_q <= 32'h0;
            pcp1_q  <= 32'h0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pcp1_q  <= pcp1_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        pcp1_d  = pcp1_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;

        if (inBranchTaken) begin
            pc_d    = inBranchTarget;
            instr_d = 32'h0;
            pcp1_d  = 32'h0;
            valid_d = 1'b0;
            state_d = (inBranchTarget < MEM_LIMIT) ? S_RUN : S_END;
        end else if (inStall) begin
            // hold everything
        end else if (state_q == S_RUN && pc_q < MEM_LIMIT) begin
            instr_d = inInstruction;
            pcp1_d  = pc_inc;
            valid_d = 1'b1;
            pc_d    = pc_inc;
            cnt_d   = cnt_q + 1'b1;
            state_d = (pc_inc == MEM_LIMIT) ? S_END : S_RUN;
        end else begin
            // END, or RUN parked on an out-of-range PC: emit bubbles
            instr_d = 32'h0;
            pcp1_d  = 32'h0;
            valid_d = 1'b0;
            state_d = S_END;
        end
    end

    assign outPC          = pc_q;
    assign outInstrIFID   = instr_q;
    assign outPCplus1IFID = pcp1_q;
    assign outValidIFID   = valid_q;
    assign outEnd         = (state_q == S_END);
    assign outFetchCount  = cnt_q;

endmodule

// File: tb/tb_fetch_pc_ifid.sv
// Directed bench for fetch_pc_ifid: vector table plus hand-written full-run and mid-run reset sequences.
module tb_fetch_pc_ifid;

    logic        clk;
    logic        reset;
    logic        inStall;
    logic        inBranchTaken;
    logic [31:0] inBranchTarget;
    logic [31:0] outPC;
    logic [31:0] inInstruction;
    logic [31:0] outInstrIFID;
    logic [31:0] outPCplus1IFID;
    logic        outValidIFID;
    logic        outEnd;
    logic [15:0] outFetchCount;

    int n_checks;
    int n_errors;

    fetch_pc_ifid #(.MEM_WORDS(32), .CNT_W(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .inStall        (inStall),
        .inBranchTaken  (inBranchTaken),
        .inBranchTarget (inBranchTarget),
        .outPC          (outPC),
        .inInstruction  (inInstruction),
        .outInstrIFID   (outInstrIFID),
        .outPCplus1IFID (outPCplus1IFID),
        .outValidIFID   (outValidIFID),
        .outEnd         (outEnd),
        .outFetchCount  (outFetchCount)
    );

    // instruction memory model: mem[k] = k+100, garbage outside program memory
    assign inInstruction = (outPC < 32'd32) ? (outPC + 32'd100) : 32'hDEADBEEF;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        stall;
        logic        br;
        logic [31:0] tgt;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pcp1;
        logic        valid;
        logic        done;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst_n, logic stall, logic br, logic [31:0] tgt,
                                logic [31:0] pc, logic [31:0] instr, logic [31:0] pcp1,
                                logic valid, logic done, logic [15:0] cnt);
        vec_t v;
        v.rst_n = rst_n; v.stall = stall; v.br = br; v.tgt = tgt;
        v.pc = pc; v.instr = instr; v.pcp1 = pcp1;
        v.valid = valid; v.done = done; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // drive inputs away from the edge, clock once, sample 1 time unit later
    task automatic step(logic rst_n, logic stall, logic br, logic [31:0] tgt);
        @(negedge clk);
        reset          = rst_n;
        inStall        = stall;
        inBranchTaken  = br;
        inBranchTarget = tgt;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(string tag, logic [31:0] pc, logic [31:0] instr, logic [31:0] pcp1,
                             logic valid, logic done, logic [15:0] cnt);
        chk({tag, ".pc"},    outPC,                  pc);
        chk({tag, ".instr"}, outInstrIFID,           instr);
        chk({tag, ".pcp1"},  outPCplus1IFID,         pcp1);
        chk({tag, ".valid"}, 32'(outValidIFID),      32'(valid));
        chk({tag, ".end"},   32'(outEnd),            32'(done));
        chk({tag, ".cnt"},   32'(outFetchCount),     32'(cnt));
    endtask

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        reset          = 1'b0;
        inStall        = 1'b0;
        inBranchTaken  = 1'b0;
        inBranchTarget = 32'h0;

        //                rst stl br tgt   pc  instr pcp1 v  end cnt
        vecs.push_back(mk(0, 0, 0, 0,      0,  0,    0,   0, 0,  0));
        vecs.push_back(mk(0, 0, 0, 0,      0,  0,    0,   0, 0,  0));
        vecs.push_back(mk(1, 0, 0, 0,      1,  100,  1,   1, 0,  1));
        vecs.push_back(mk(1, 0, 0, 0,      2,  101,  2,   1, 0,  2));
        vecs.push_back(mk(1, 0, 0, 0,      3,  102,  3,   1, 0,  3));
        vecs.push_back(mk(1, 0, 0, 0,      4,  103,  4,   1, 0,  4));
        vecs.push_back(mk(1, 1, 0, 0,      4,  103,  4,   1, 0,  4));
        vecs.push_back(mk(1, 1, 0, 0,      4,  103,  4,   1, 0,  4));
        vecs.push_back(mk(1, 1, 0, 0,      4,  103,  4,   1, 0,  4));
        vecs.push_back(mk(1, 0, 0, 0,      5,  104,  5,   1, 0,  5));
        vecs.push_back(mk(1, 0, 0, 0,      6,  105,  6,   1, 0,  6));
        vecs.push_back(mk(1, 0, 1, 2,      2,  0,    0,   0, 0,  6));
        vecs.push_back(mk(1, 0, 0, 0,      3,  102,  3,   1, 0,  7));
        vecs.push_back(mk(1, 1, 1, 10,     10, 0,    0,   0, 0,  7));
        vecs.push_back(mk(1, 0, 0, 0,      11, 110,  11,  1, 0,  8));
        vecs.push_back(mk(1, 0, 1, 30,     30, 0,    0,   0, 0,  8));
        vecs.push_back(mk(1, 0, 0, 0,      31, 130,  31,  1, 0,  9));
        vecs.push_back(mk(1, 0, 0, 0,      32, 131,  32,  1, 1,  10));
        vecs.push_back(mk(1, 1, 0, 0,      32, 131,  32,  1, 1,  10));
        vecs.push_back(mk(1, 0, 0, 0,      32, 0,    0,   0, 1,  10));
        vecs.push_back(mk(1, 0, 0, 0,      32, 0,    0,   0, 1,  10));
        vecs.push_back(mk(1, 0, 1, 40,     40, 0,    0,   0, 1,  10));
        vecs.push_back(mk(1, 0, 0, 0,      40, 0,    0,   0, 1,  10));
        vecs.push_back(mk(1, 0, 1, 0,      0,  0,    0,   0, 0,  10));
        vecs.push_back(mk(1, 0, 0, 0,      1,  100,  1,   1, 0,  11));
        vecs.push_back(mk(0, 1, 1, 5,      0,  0,    0,   0, 0,  0));
        vecs.push_back(mk(1, 0, 0, 0,      1,  100,  1,   1, 0,  1));

        foreach (vecs[i]) begin
            step(vecs[i].rst_n, vecs[i].stall, vecs[i].br, vecs[i].tgt);
            check_all($sformatf("vec%0d", i), vecs[i].pc, vecs[i].instr, vecs[i].pcp1,
                      vecs[i].valid, vecs[i].done, vecs[i].cnt);
        end

        // full sequential run through program memory into END
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check_all("run_rst", 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 16'd0);
        for (int k = 0; k < 32; k++) begin
            step(1'b1, 1'b0, 1'b0, 32'h0);
            check_all($sformatf("run%0d", k), 32'(k + 1), 32'(k + 100), 32'(k + 1),
                      1'b1, (k == 31), 16'(k + 1));
        end
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check_all("run_end", 32'd32, 32'd0, 32'd0, 1'b0, 1'b1, 16'd32);

        // reset mid-run at PC=7, count=7
        step(1'b1, 1'b0, 1'b1, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 7; k++) step(1'b1, 1'b0, 1'b0, 32'h0);
        check_all("mid_pre", 32'd7, 32'd106, 32'd7, 1'b1, 1'b0, 16'd7);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check_all("mid_rst", 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 16'd0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check_all("mid_post", 32'd1, 32'd100, 32'd1, 1'b1, 1'b0, 16'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
